decode_operand_stage: RTL

- Decode/operand-fetch stage directly upstream of the BRAM-based register file. It also supplies the execute stage.
- Accepts one fetched RV32I instruction at a time and drives the register-file read addresses in the accept cycle.
- Waits the fixed one-cycle BRAM read latency and merges writeback bypass data. BRAM read-during-write returns old data.
- Presents PC, instruction, rs1/rs2 values, sign-extended immediate and rd to execute over a valid/ready handshake.

---
 rtl/decode_operand_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/decode_operand_stage.sv
// RV32I decode/operand-fetch stage feeding a BRAM register file (1-cycle read).
// Merges writeback bypass data and hands a decoded bundle to execute over valid/ready.
module decode_operand_stage #(
  parameter int XLEN          = 32,
  parameter bit RESET_PC_HOLD = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      ra1,
  output logic [4:0]      ra2,
  output logic            new_instr,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_wa,
  input  logic [XLEN-1:0] wb_wd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd
);

  typedef enum logic [1:0] {IDLE, READ, OUT} state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } req_t;

  state_t          state;
  req_t            req_q;
  logic            byp1_f, byp2_f;
  logic [XLEN-1:0] byp1_d, byp2_d;
  logic            accept, hit1, hit2;
  logic [XLEN-1:0] op1, op2;

  function automatic logic [31:0] imm_gen(input logic [31:0] i);
    case (i[6:0])
      7'b0010011, 7'b0000011,
      7'b1100111, 7'b1110011: imm_gen = {{20{i[31]}}, i[31:20]};
      7'b0100011:             imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011:             imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm_gen = {i[31:12], 12'b0};
      7'b1101111:             imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:                imm_gen = '0;
    endcase
  endfunction

  assign in_ready  = !reset && !flush && (state == IDLE || (state == OUT && out_ready));
  assign accept    = in_valid && in_ready;
  assign new_instr = accept;
  assign ra1       = accept ? in_instr[19:15] : req_q.rs1;
  assign ra2       = accept ? in_instr[24:20] : req_q.rs2;

  // A live writeback wins over both the captured bypass and the (stale) BRAM data.
  assign hit1 = wb_we && (wb_wa == req_q.rs1) && (req_q.rs1 != 5'd0);
  assign hit2 = wb_we && (wb_wa == req_q.rs2) && (req_q.rs2 != 5'd0);

  always_comb begin
    op1 = rd1;
    if (req_q.rs1 == 5'd0) op1 = '0;
    else if (hit1)         op1 = wb_wd;
    else if (byp1_f)       op1 = byp1_d;
    op2 = rd2;
    if (req_q.rs2 == 5'd0) op2 = '0;
    else if (hit2)         op2 = wb_wd;
    else if (byp2_f)       op2 = byp2_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_q       <= '0;
      byp1_f      <= 1'b0;
      byp2_f      <= 1'b0;
      byp1_d      <= '0;
      byp2_d      <= '0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_instr   <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      byp1_f    <= 1'b0;
      byp2_f    <= 1'b0;
      if (!RESET_PC_HOLD) out_pc <= '0;
    end else begin
      if (accept) begin
        req_q.instr <= in_instr;
        req_q.pc    <= in_pc;
        req_q.rs1   <= in_instr[19:15];
        req_q.rs2   <= in_instr[24:20];
        req_q.rd    <= in_instr[11:7];
        // BRAM returns old data on read-during-write, so catch the write here.
        byp1_f      <= wb_we && (wb_wa == in_instr[19:15]) && (wb_wa != 5'd0);
        byp2_f      <= wb_we && (wb_wa == in_instr[24:20]) && (wb_wa != 5'd0);
        byp1_d      <= wb_wd;
        byp2_d      <= wb_wd;
        state       <= READ;
      end
      case (state)
        READ: begin
          out_pc      <= req_q.pc;
          out_instr   <= req_q.instr;
          out_rs1_val <= op1;
          out_rs2_val <= op2;
          out_imm     <= imm_gen(req_q.instr);
          out_rd      <= req_q.rd;
          out_valid   <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (hit1) out_rs1_val <= wb_wd;
          if (hit2) out_rs2_val <= wb_wd;
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!accept) state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
